sudoku_group_seq: RTL and testbench

SUDOKU_GROUP_SEQ -- requirements
Module: sudoku_group_seq

---
 rtl/sudoku_pkg.sv | 23 ++
 rtl/sudoku_group_seq.sv | 155 +++++++++++++++
 tb/tb_sudoku_group_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku group sequencer.
package sudoku_pkg;

    localparam int unsigned NCELL_C = 9;
    localparam int unsigned DIGIT_W = 9;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned PASS_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        APPLY,
        COMMIT,
        CHECK
    } state_e;

    typedef enum logic [1:0] {
        RES_SOLVED   = 2'd0,
        RES_STUCK    = 2'd1,
        RES_CONFLICT = 2'd2
    } result_e;

endpackage

// File: rtl/sudoku_group_seq.sv
// Sequences constraint propagation over one 9-cell sudoku group on a shared digit bus.
// Define SUDOKU_SEQ_CONFLICT_EN to compile in duplicate-digit conflict detection.
module sudoku_group_seq
    import sudoku_pkg::*;
#(
    parameter int unsigned MAX_PASSES = 9,
    parameter int unsigned NCELL      = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [1:0]         result,
    output logic [PASS_W-1:0]  passes,
    inout  wire  [DIGIT_W-1:0] value_io,
    output logic [NCELL-1:0]   cell_oe,
    output logic [1:0]         address,
    output logic               we,
    output logic               latch_valid,
    output logic               latch_singleton,
    input  logic [NCELL-1:0]   is_singleton,
    input  logic [NCELL-1:0]   solved
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGIT_W-1:0]  used_q, used_d;
    logic [PASS_W-1:0]   passes_q, passes_d;
    logic                progress_q, progress_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    result_e             result_q, result_d;
    logic [NCELL-1:0]    cell_oe_q, cell_oe_d;
    logic                latch_valid_q, latch_valid_d;
    logic                latch_singleton_q, latch_singleton_d;
    logic                conflict_c;
    logic                drive_c;

`ifdef SUDOKU_SEQ_CONFLICT_EN
    assign conflict_c = |(used_q & value_io);
`else
    assign conflict_c = 1'b0;
`endif

    // Bus enable is combinational so reset releases the bus within the same cycle.
    assign drive_c  = (state_q == APPLY) && !reset;
    assign value_io = drive_c ? ~used_q : {DIGIT_W{1'bz}};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        used_d     = used_q;
        passes_d   = passes_q;
        progress_d = progress_q;
        result_d   = result_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    used_d   = '0;
                    passes_d = '0;
                    idx_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                used_d = used_q | value_io;
                if (conflict_c) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    result_d = RES_CONFLICT;
                end else if (idx_q == IDX_W'(NCELL_C - 1)) begin
                    state_d = APPLY;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            APPLY: begin
                state_d = COMMIT;
            end
            COMMIT: begin
                progress_d = |(is_singleton & ~solved);
                state_d    = CHECK;
            end
            CHECK: begin
                if (passes_q < PASS_W'(MAX_PASSES)) begin
                    passes_d = passes_q + PASS_W'(1);
                end
                if (&solved) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    result_d = RES_SOLVED;
                end else if (progress_q && (passes_d < PASS_W'(MAX_PASSES))) begin
                    used_d  = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end else begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    result_d = RES_STUCK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are derived from the next state so they line up with state_q.
        busy_d            = (state_d != IDLE);
        cell_oe_d         = (state_d == SCAN) ? (NCELL'(1) << idx_d) : '0;
        latch_valid_d     = (state_d == APPLY);
        latch_singleton_d = (state_d == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            idx_q             <= '0;
            used_q            <= '0;
            passes_q          <= '0;
            progress_q        <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            result_q          <= RES_SOLVED;
            cell_oe_q         <= '0;
            latch_valid_q     <= 1'b0;
            latch_singleton_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            used_q            <= used_d;
            passes_q          <= passes_d;
            progress_q        <= progress_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            result_q          <= result_d;
            cell_oe_q         <= cell_oe_d;
            latch_valid_q     <= latch_valid_d;
            latch_singleton_q <= latch_singleton_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign result          = result_q;
    assign passes          = passes_q;
    assign cell_oe         = cell_oe_q;
    assign latch_valid     = latch_valid_q;
    assign latch_singleton = latch_singleton_q;
    assign address         = 2'b00;
    assign we              = 1'b0;

endmodule

// File: tb/tb_sudoku_group_seq.sv
// Bench for sudoku_group_seq: behavioural cells on the bus plus a pass-level expected trace.
`timescale 1ns/1ps
module tb_sudoku_group_seq;

    localparam int unsigned MAXP = 3;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       busy, done;
    logic [1:0] result;
    logic [3:0] passes;
    wire  [8:0] value_io;
    logic [8:0] cell_oe;
    logic [1:0] address;
    logic       we, latch_valid, latch_singleton;
    logic [8:0] is_singleton, solved;

    sudoku_group_seq #(.MAX_PASSES(MAXP), .NCELL(9)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .result(result), .passes(passes), .value_io(value_io), .cell_oe(cell_oe),
        .address(address), .we(we), .latch_valid(latch_valid),
        .latch_singleton(latch_singleton), .is_singleton(is_singleton), .solved(solved)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit single(input logic [8:0] m);
        return $countones(m) == 1;
    endfunction

    // ---------------- behavioural cells ----------------
    logic [8:0] env_cand [9];
    logic [8:0] env_sol;
    logic [8:0] ld_cand [9];
    logic [8:0] ld_sol;
    logic       ld_req;
    logic       force_prog;
    logic [8:0] env_bus;
    logic [8:0] sing_c;
    logic       bus_z;

    always_comb begin
        env_bus = '0;
        sing_c  = '0;
        for (int i = 0; i < 9; i++) begin
            if (cell_oe[i] && env_sol[i]) env_bus = env_bus | env_cand[i];
            sing_c[i] = single(env_cand[i]);
        end
    end

    assign value_io     = (|cell_oe) ? env_bus : 9'bz;
    assign is_singleton = force_prog ? 9'h1FF : sing_c;
    assign solved       = force_prog ? 9'h000 : env_sol;
    assign bus_z        = (value_io === 9'bz);

    always @(posedge clk) begin
        if (ld_req) begin
            for (int i = 0; i < 9; i++) env_cand[i] <= ld_cand[i];
            env_sol <= ld_sol;
        end else if (!reset) begin
            for (int i = 0; i < 9; i++) begin
                if (latch_valid && !env_sol[i]) env_cand[i] <= env_cand[i] & value_io;
                if (latch_singleton && !env_sol[i] && sing_c[i]) env_sol[i] <= 1'b1;
            end
        end
    end

    // ---------------- reference model: expected per-cycle trace ----------------
    typedef struct packed {
        logic [8:0] oe;
        logic       lv;
        logic       ls;
        logic       bsy;
        logic       dn;
        logic [1:0] res;
        logic [3:0] ps;
        logic [8:0] bus;
    } exp_t;

    exp_t expq[$];

    function automatic exp_t mk(input logic [8:0] oe, input logic lv, input logic ls,
                                input logic bsy, input logic dn, input logic [1:0] res,
                                input int ps, input logic [8:0] bus);
        exp_t e;
        e.oe = oe; e.lv = lv; e.ls = ls; e.bsy = bsy; e.dn = dn;
        e.res = res; e.ps = 4'(ps); e.bus = bus;
        return e;
    endfunction

    task automatic build_trace();
        logic [8:0] c [9];
        logic [8:0] s, used, v;
        int p;
        bit conf, prog, fin;
        c = ld_cand; s = ld_sol; p = 0; fin = 0;
        while (!fin) begin
            used = '0; conf = 0;
            for (int i = 0; i < 9 && !conf; i++) begin
                expq.push_back(mk(9'(1) << i, 0, 0, 1, 0, 2'd0, p, 9'h0));
                v = s[i] ? c[i] : 9'h0;
`ifdef SUDOKU_SEQ_CONFLICT_EN
                if ((v & used) != 9'h0) conf = 1;
`endif
                used = used | v;
            end
            if (conf) begin
                expq.push_back(mk(9'h0, 0, 0, 0, 1, 2'd2, p, 9'h0));
                fin = 1;
            end else begin
                expq.push_back(mk(9'h0, 1, 0, 1, 0, 2'd0, p, ~used));
                for (int i = 0; i < 9; i++) if (!s[i]) c[i] = c[i] & ~used;
                expq.push_back(mk(9'h0, 0, 1, 1, 0, 2'd0, p, 9'h0));
                prog = force_prog;
                for (int i = 0; i < 9; i++) begin
                    if (!s[i] && single(c[i])) begin
                        prog = 1;
                        s[i] = 1'b1;
                    end
                end
                expq.push_back(mk(9'h0, 0, 0, 1, 0, 2'd0, p, 9'h0));
                if (p < int'(MAXP)) p++;
                if (!force_prog && (&s)) begin
                    expq.push_back(mk(9'h0, 0, 0, 0, 1, 2'd0, p, 9'h0));
                    fin = 1;
                end else if (!(prog && p < int'(MAXP))) begin
                    expq.push_back(mk(9'h0, 0, 0, 0, 1, 2'd1, p, 9'h0));
                    fin = 1;
                end
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    exp_t       cur;
    logic       skip;
    logic [3:0] last_passes;
    logic [8:0] apply_bus_seen;

    always @(negedge clk) begin
        if (!reset && !skip) begin
            check("addr", 32'(address), 32'h0);
            check("we", 32'(we), 32'h0);
            check("oe_excl", 32'((|cell_oe) && (latch_valid || latch_singleton)), 32'h0);
            if (expq.size() > 0) begin
                cur = expq.pop_front();
                check("cell_oe", 32'(cell_oe), 32'(cur.oe));
                check("latch_valid", 32'(latch_valid), 32'(cur.lv));
                check("latch_singleton", 32'(latch_singleton), 32'(cur.ls));
                check("busy", 32'(busy), 32'(cur.bsy));
                check("done", 32'(done), 32'(cur.dn));
                check("passes", 32'(passes), 32'(cur.ps));
                if (cur.dn) begin
                    check("result", 32'(result), 32'(cur.res));
                    last_passes = cur.ps;
                end
                if (cur.lv) begin
                    check("apply_bus", 32'(value_io), 32'(cur.bus));
                    apply_bus_seen = value_io;
                end else if (cur.oe != 9'h0) begin
                    check("scan_bus", 32'(value_io), 32'(env_bus));
                end else begin
                    check("bus_released", 32'(bus_z), 32'h1);
                end
            end else begin
                check("idle_busy", 32'(busy), 32'h0);
                check("idle_done", 32'(done), 32'h0);
                check("idle_oe", 32'(cell_oe), 32'h0);
                check("idle_lv", 32'(latch_valid), 32'h0);
                check("idle_ls", 32'(latch_singleton), 32'h0);
                check("idle_passes", 32'(passes), 32'(last_passes));
                check("idle_bus_z", 32'(bus_z), 32'h1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load();
        @(posedge clk); #1 ld_req = 1'b1;
        @(posedge clk); #1 ld_req = 1'b0;
    endtask

    task automatic run(input int poke, output logic [1:0] r, output logic [3:0] p, output int cyc);
        bit got;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        build_trace();
        cyc = 0; r = 2'd0; p = 4'd0; got = 0;
        while (cyc < 400 && !got) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                r = result;
                p = passes;
            end else begin
                cyc++;
                start = (poke > 0) && (cyc % poke == 0);
            end
        end
        start = 1'b0;
        if (!got) begin
            check("done_timeout", 32'h0, 32'h1);
            expq.delete();
        end
    endtask

    task automatic set_empty();
        for (int i = 0; i < 9; i++) ld_cand[i] = 9'h1FF;
        ld_sol = 9'h000;
    endtask

    task automatic set_eight();
        for (int i = 0; i < 8; i++) ld_cand[i] = 9'(1) << i;
        ld_cand[8] = 9'h1FF;
        ld_sol = 9'h0FF;
    endtask

    task automatic set_random();
        int unsigned r;
        for (int i = 0; i < 9; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                ld_cand[i] = 9'(1) << $urandom_range(0, 8);
                ld_sol[i]  = 1'b1;
            end else begin
                ld_cand[i] = (9'($urandom) & 9'($urandom)) | (9'(1) << $urandom_range(0, 8));
                ld_sol[i]  = 1'b0;
            end
        end
    endtask

    logic [1:0] r;
    logic [3:0] p;
    int         cyc;
    int         waited;

    initial begin
        reset = 1'b1; start = 1'b0; ld_req = 1'b0; force_prog = 1'b0;
        skip = 1'b0; last_passes = 4'd0; apply_bus_seen = 9'h0;
        set_empty();
        for (int i = 0; i < 9; i++) env_cand[i] = 9'h1FF;
        env_sol = 9'h0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_oe", 32'(cell_oe), 32'h0);
        check("rst_lv", 32'(latch_valid), 32'h0);
        check("rst_ls", 32'(latch_singleton), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_passes", 32'(passes), 32'h0);
        check("rst_bus_z", 32'(bus_z), 32'h1);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        // eight digits placed, last cell empty
        set_eight(); load(); run(0, r, p, cyc);
        check("eight_result", 32'(r), 32'h0);
        check("eight_passes", 32'(p), 32'h1);
        check("eight_latency", 32'(cyc), 32'd12);
        check("eight_apply_mask", 32'(apply_bus_seen), 32'h100);

        // all empty
        set_empty(); load(); run(0, r, p, cyc);
        check("empty_result", 32'(r), 32'h1);
        check("empty_passes", 32'(p), 32'h1);

        // duplicate digit 5 in cells 0 and 1
        set_empty();
        ld_cand[0] = 9'h010; ld_cand[1] = 9'h010; ld_sol = 9'h003;
        load(); run(0, r, p, cyc);
`ifdef SUDOKU_SEQ_CONFLICT_EN
        check("dup_result", 32'(r), 32'h2);
        check("dup_passes", 32'(p), 32'h0);
        check("dup_latency", 32'(cyc), 32'd2);
`else
        check("dup_result", 32'(r), 32'h1);
        check("dup_passes", 32'(p), 32'h1);
        check("dup_latency", 32'(cyc), 32'd12);
`endif

        // progress forced every pass, with start pulsed while busy
        set_empty(); force_prog = 1'b1; load(); run(7, r, p, cyc);
        #1 force_prog = 1'b0;
        check("force_result", 32'(r), 32'h1);
        check("force_passes", 32'(p), 32'd3);
        check("force_latency", 32'(cyc), 32'd36);

        // reset during APPLY
        set_eight(); load();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        build_trace();
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!latch_valid && waited < 20);
        check("apply_reached", 32'(latch_valid), 32'h1);
        skip = 1'b1;
        reset = 1'b1;
        expq.delete();
        #1 check("rst_apply_bus_z", 32'(bus_z), 32'h1);
        @(posedge clk); #1;
        check("rst_apply_busy", 32'(busy), 32'h0);
        check("rst_apply_oe", 32'(cell_oe), 32'h0);
        check("rst_apply_lv", 32'(latch_valid), 32'h0);
        check("rst_apply_ls", 32'(latch_singleton), 32'h0);
        check("rst_apply_done", 32'(done), 32'h0);
        check("rst_apply_bus", 32'(bus_z), 32'h1);
        reset = 1'b0; last_passes = 4'd0; skip = 1'b0;
        set_eight(); load(); run(0, r, p, cyc);
        check("after_rst_result", 32'(r), 32'h0);
        check("after_rst_passes", 32'(p), 32'h1);

        // randomized groups against the model
        for (int k = 0; k < 30; k++) begin
            set_random(); load(); run(0, r, p, cyc);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
